addernet_row_feeder: RTL and testbench

ADDERNET_ROW_FEEDER -- requirements
Module: addernet_row_feeder

---
 rtl/addernet_row_feeder.sv | 153 +++++++++++++++
 tb/tb_addernet_row_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addernet_row_feeder.sv
// AdderNet row feeder: loads one weight into a PE row, then streams a
// skewed X vector into it, with a flush cycle and a done pulse.
module addernet_row_feeder #(
    parameter int BIT_WIDTH_XW  = 8,
    parameter int SKEW          = 0,
    parameter int BIT_WIDTH_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_Start,
    input  logic [BIT_WIDTH_LEN-1:0] i_Len,
    input  logic                     i_Wvalid,
    output logic                     o_Wready,
    input  logic [BIT_WIDTH_XW-1:0]  i_Wdata,
    input  logic                     i_Wneg,
    input  logic                     i_Xvalid,
    output logic                     o_Xready,
    input  logic [BIT_WIDTH_XW-1:0]  i_Xdata,
    output logic [BIT_WIDTH_XW-1:0]  o_X,
    output logic [BIT_WIDTH_XW-1:0]  o_W,
    output logic                     o_StoreW,
    output logic                     o_NegZeroW,
    output logic                     o_Busy,
    output logic                     o_Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_SKEW,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [4:0] SKEW_INIT = 5'(SKEW);

    state_t                   state;
    state_t                   state_nxt;
    logic [BIT_WIDTH_LEN-1:0] len_q;
    logic [BIT_WIDTH_LEN-1:0] xcnt;
    logic [BIT_WIDTH_LEN-1:0] xcnt_inc;
    logic [4:0]               skew_cnt;
    logic                     w_xfer;
    logic                     x_xfer;
    logic                     x_last;
    logic                     len_zero;

    // Handshake readies and busy are pure decodes of the state register.
    assign o_Busy   = (state != S_IDLE);
    assign o_Wready = (state == S_LOADW);
    assign o_Xready = (state == S_STREAM);

    assign w_xfer   = o_Wready & i_Wvalid;
    assign x_xfer   = o_Xready & i_Xvalid;
    // xcnt < len_q whenever streaming, so the increment cannot overflow.
    assign xcnt_inc = xcnt + 1'b1;
    assign x_last   = (xcnt_inc == len_q);
    assign len_zero = (len_q == '0);

    // Next-state decode for the job sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_Start) begin
                    state_nxt = S_LOADW;
                end
            end
            S_LOADW: begin
                if (w_xfer) begin
                    if (SKEW != 0) begin
                        state_nxt = S_SKEW;
                    end else if (!len_zero) begin
                        state_nxt = S_STREAM;
                    end else begin
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_SKEW: begin
                if (skew_cnt <= 5'd1) begin
                    state_nxt = len_zero ? S_FLUSH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (x_xfer && x_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job length latch, X transfer counter and skew down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            xcnt     <= '0;
            skew_cnt <= '0;
        end else begin
            if (state == S_IDLE && i_Start) begin
                len_q <= i_Len;
                xcnt  <= '0;
            end
            if (w_xfer) begin
                skew_cnt <= SKEW_INIT;
            end else if (state == S_SKEW) begin
                skew_cnt <= skew_cnt - 5'd1;
            end
            if (x_xfer) begin
                xcnt <= xcnt_inc;
            end
        end
    end

    // Registered drive to the PE row; weight and bypass hold between jobs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_X        <= '0;
            o_W        <= '0;
            o_StoreW   <= 1'b0;
            o_NegZeroW <= 1'b0;
            o_Done     <= 1'b0;
        end else begin
            o_X      <= x_xfer ? i_Xdata : '0;
            o_StoreW <= w_xfer;
            o_Done   <= (state == S_FLUSH);
            if (w_xfer) begin
                o_W        <= i_Wdata;
                o_NegZeroW <= i_Wneg;
            end
        end
    end

endmodule

// File: tb/tb_addernet_row_feeder.sv
// Scoreboard bench for addernet_row_feeder: per-cycle expected output
// vectors are queued up front and popped by monitors while a DUT is busy.
module tb_addernet_row_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start3;
    logic [7:0] i_len;
    logic       wvalid, wneg, xvalid;
    logic [7:0] wdata, xdata;

    logic       wr0, xr0, sw0, nz0, busy0, dn0;
    logic [7:0] x0, w0;
    logic       wr3, xr3, sw3, nz3, busy3, dn3;
    logic [7:0] x3, w3;

    logic [20:0] obs0, obs3;
    logic [20:0] q0[$];
    logic [20:0] q3[$];
    logic [7:0]  xs[256];
    logic        vpat[16];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    addernet_row_feeder #(.BIT_WIDTH_XW(8), .SKEW(0), .BIT_WIDTH_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .i_Start(start0), .i_Len(i_len),
        .i_Wvalid(wvalid), .o_Wready(wr0), .i_Wdata(wdata), .i_Wneg(wneg),
        .i_Xvalid(xvalid), .o_Xready(xr0), .i_Xdata(xdata),
        .o_X(x0), .o_W(w0), .o_StoreW(sw0), .o_NegZeroW(nz0),
        .o_Busy(busy0), .o_Done(dn0)
    );

    addernet_row_feeder #(.BIT_WIDTH_XW(8), .SKEW(3), .BIT_WIDTH_LEN(8)) dut3 (
        .clk(clk), .rst(rst), .i_Start(start3), .i_Len(i_len),
        .i_Wvalid(wvalid), .o_Wready(wr3), .i_Wdata(wdata), .i_Wneg(wneg),
        .i_Xvalid(xvalid), .o_Xready(xr3), .i_Xdata(xdata),
        .o_X(x3), .o_W(w3), .o_StoreW(sw3), .o_NegZeroW(nz3),
        .o_Busy(busy3), .o_Done(dn3)
    );

    assign obs0 = {wr0, xr0, sw0, dn0, nz0, x0, w0};
    assign obs3 = {wr3, xr3, sw3, dn3, nz3, x3, w3};

    function automatic logic [20:0] ob(input logic wr, input logic xr,
                                       input logic sw, input logic dn,
                                       input logic nz, input logic [7:0] x,
                                       input logic [7:0] w);
        return {wr, xr, sw, dn, nz, x, w};
    endfunction

    function automatic void chk(input string nm, input logic [20:0] act,
                                input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor for the SKEW=0 instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && (busy0 || dn0)) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon0_unexpected: got %h expected none", obs0);
            end else begin
                chk("mon0", obs0, q0.pop_front());
            end
        end
    end

    // Monitor for the SKEW=3 instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && (busy3 || dn3)) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon3_unexpected: got %h expected none", obs3);
            end else begin
                chk("mon3", obs3, q3.pop_front());
            end
        end
    end

    task automatic push(input bit sel, input logic [20:0] v);
        if (sel) q3.push_back(v);
        else q0.push_back(v);
    endtask

    // Drives one job with a handshake-respecting driver until o_Done.
    task automatic run_job(input bit sel, input logic [7:0] l,
                           input logic [7:0] w, input logic n,
                           input int nvp);
        int  xi = 0;
        int  vi = 0;
        int  cyc = 0;
        bit  wdone = 0;
        bit  fin = 0;
        logic wr_s, xr_s, dn_s;
        @(negedge clk);
        if (sel) start3 = 1'b1;
        else start0 = 1'b1;
        i_len  = l;
        wvalid = 1'b1;
        wdata  = w;
        wneg   = n;
        xvalid = 1'b0;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            wr_s = sel ? wr3 : wr0;
            xr_s = sel ? xr3 : xr0;
            dn_s = sel ? dn3 : dn0;
            start0 = 1'b0;
            start3 = 1'b0;
            if (wdone) wvalid = 1'b0;
            xvalid = (vi < nvp) ? vpat[vi] : 1'b1;
            xdata  = xs[xi];
            if (wvalid && wr_s) wdone = 1;
            if (xr_s) begin
                if (xvalid) xi++;
                vi++;
            end
            if (dn_s) fin = 1;
        end
        xvalid = 1'b0;
        wvalid = 1'b0;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL job_timeout: got no done expected done");
        end
    endtask

    task automatic finish_job(input bit sel);
        @(negedge clk);
        chk("idle_busy", {20'd0, sel ? busy3 : busy0}, 21'd0);
        chk("queue_empty", 21'(sel ? q3.size() : q0.size()), 21'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start3 = 1'b0;
        i_len  = '0;
        wvalid = 1'b0;
        wdata  = '0;
        wneg   = 1'b0;
        xvalid = 1'b0;
        xdata  = '0;
        for (int i = 0; i < 256; i++) xs[i] = '0;
        for (int i = 0; i < 16; i++) vpat[i] = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_obs0", obs0, 21'd0);
        chk("rst_obs3", obs3, 21'd0);
        chk("rst_busy", {19'd0, busy0, busy3}, 21'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic job: no skew, three back-to-back X values.
        xs[0] = 8'h10; xs[1] = 8'h20; xs[2] = 8'h30;
        push(0, ob(1, 0, 0, 0, 0, 8'h00, 8'h00));
        push(0, ob(0, 1, 1, 0, 0, 8'h00, 8'h40));
        push(0, ob(0, 1, 0, 0, 0, 8'h10, 8'h40));
        push(0, ob(0, 1, 0, 0, 0, 8'h20, 8'h40));
        push(0, ob(0, 0, 0, 0, 0, 8'h30, 8'h40));
        push(0, ob(0, 0, 0, 1, 0, 8'h00, 8'h40));
        run_job(0, 8'd3, 8'h40, 1'b0, 0);
        finish_job(0);

        // Skewed row: three idle zero cycles before streaming.
        xs[0] = 8'h11; xs[1] = 8'h22;
        push(1, ob(1, 0, 0, 0, 0, 8'h00, 8'h00));
        push(1, ob(0, 0, 1, 0, 0, 8'h00, 8'h05));
        push(1, ob(0, 0, 0, 0, 0, 8'h00, 8'h05));
        push(1, ob(0, 0, 0, 0, 0, 8'h00, 8'h05));
        push(1, ob(0, 1, 0, 0, 0, 8'h00, 8'h05));
        push(1, ob(0, 1, 0, 0, 0, 8'h11, 8'h05));
        push(1, ob(0, 0, 0, 0, 0, 8'h22, 8'h05));
        push(1, ob(0, 0, 0, 1, 0, 8'h00, 8'h05));
        run_job(1, 8'd2, 8'h05, 1'b0, 0);
        finish_job(1);

        // Gappy X stream produces zero bubbles.
        xs[0] = 8'hA1; xs[1] = 8'hA2; xs[2] = 8'hA3; xs[3] = 8'hA4;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 1;
        vpat[3] = 0; vpat[4] = 1; vpat[5] = 1;
        push(0, ob(1, 0, 0, 0, 0, 8'h00, 8'h40));
        push(0, ob(0, 1, 1, 0, 0, 8'h00, 8'h07));
        push(0, ob(0, 1, 0, 0, 0, 8'hA1, 8'h07));
        push(0, ob(0, 1, 0, 0, 0, 8'h00, 8'h07));
        push(0, ob(0, 1, 0, 0, 0, 8'hA2, 8'h07));
        push(0, ob(0, 1, 0, 0, 0, 8'h00, 8'h07));
        push(0, ob(0, 1, 0, 0, 0, 8'hA3, 8'h07));
        push(0, ob(0, 0, 0, 0, 0, 8'hA4, 8'h07));
        push(0, ob(0, 0, 0, 1, 0, 8'h00, 8'h07));
        run_job(0, 8'd4, 8'h07, 1'b0, 6);
        finish_job(0);

        // Zero length with a non-positive weight.
        push(0, ob(1, 0, 0, 0, 0, 8'h00, 8'h07));
        push(0, ob(0, 0, 1, 0, 1, 8'h00, 8'h09));
        push(0, ob(0, 0, 0, 1, 1, 8'h00, 8'h09));
        run_job(0, 8'd0, 8'h09, 1'b1, 0);
        finish_job(0);
        repeat (3) @(negedge clk);
        chk("idle_negzero_hold", {20'd0, nz0}, 21'd1);
        chk("idle_w_hold", {13'd0, w0}, 21'h09);

        // Restart ignored mid-stream, then reset aborts the job.
        push(0, ob(1, 0, 0, 0, 1, 8'h00, 8'h09));
        push(0, ob(0, 1, 1, 0, 0, 8'h00, 8'h03));
        push(0, ob(0, 1, 0, 0, 0, 8'hB1, 8'h03));
        push(0, ob(0, 1, 0, 0, 0, 8'hB2, 8'h03));
        @(negedge clk);
        start0 = 1'b1; i_len = 8'd5; wvalid = 1'b1; wdata = 8'h03; wneg = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        wvalid = 1'b0; start0 = 1'b1; i_len = 8'd1;
        xvalid = 1'b1; xdata = 8'hB1;
        @(negedge clk);
        start0 = 1'b0; xdata = 8'hB2;
        @(negedge clk);
        #2 rst = 1'b1;
        xvalid = 1'b0;
        #1;
        chk("abort_obs", obs0, 21'd0);
        chk("abort_busy", {20'd0, busy0}, 21'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_queue", 21'(q0.size()), 21'd0);
        repeat (6) @(negedge clk);
        chk("abort_idle", {19'd0, busy0, dn0}, 21'd0);

        // Maximum length streams exactly 255 values.
        for (int i = 0; i < 255; i++) xs[i] = 8'(i + 1);
        push(0, ob(1, 0, 0, 0, 0, 8'h00, 8'h00));
        push(0, ob(0, 1, 1, 0, 0, 8'h00, 8'h0F));
        for (int i = 0; i < 254; i++) begin
            push(0, ob(0, 1, 0, 0, 0, 8'(i + 1), 8'h0F));
        end
        push(0, ob(0, 0, 0, 0, 0, 8'hFF, 8'h0F));
        push(0, ob(0, 0, 0, 1, 0, 8'h00, 8'h0F));
        run_job(0, 8'hFF, 8'h0F, 1'b0, 0);
        finish_job(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
